// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the asynchronous-handshake memory controller.
package mem_ctrl_pkg;

    localparam int DEFAULT_AW = 16;
    localparam int DEFAULT_DW = 16;

    // Memory RW pin encoding
    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        RELEASE
    } state_t;

endpackage

// File: rtl/mfc_sync.sv
// Two-flop synchroniser for asynchronous handshake inputs (MFC and similar).
module mfc_sync #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    // Resample the asynchronous input twice; both stages clear to 0 on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            // NOTE: non-blocking assignments let both stages sample the old values
            // on the same edge, which is what makes this a two-stage shift.
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter and EN/RW/MFC handshake sequencer for the
// asynchronous memory. Port 0 is instruction fetch, port 1 is load/store.
module mem_arbiter
    import mem_ctrl_pkg::*;
#(
    parameter int AW      = DEFAULT_AW,
    parameter int DW      = DEFAULT_DW,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          rw0,
    input  logic          rw1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          done0,
    output logic          done1,
    output logic          err,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic          mem_en,
    output logic          mem_rw,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_mfc
);

    localparam int CW = $clog2(TIMEOUT + 1);
    // The counter holds the number of completed cycles in the current state,
    // so a value of TIMEOUT-1 means this is the TIMEOUT-th cycle spent there.
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t        state, state_next;
    logic [CW-1:0] cnt;
    logic          cnt_hit;
    logic          mfc_s;
    logic          gnt;       // port currently / most recently granted
    logic          err_flag;  // strobe phase timed out

    logic          do_grant;
    logic          grant_port;
    logic          do_capture;
    logic          strobe_timeout;
    logic          do_finish;
    logic          fin_err;

    mfc_sync #(.W(1)) u_mfc_sync (
        .clk   (clk),
        .reset (reset),
        .d     (mem_mfc),
        .q     (mfc_s)
    );

    assign cnt_hit = (cnt == CNT_LAST);
    assign busy    = (state != IDLE);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic, arbitration and per-cycle control strobes.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned, which would infer a latch.
        state_next     = state;
        do_grant       = 1'b0;
        grant_port     = gnt;
        do_capture     = 1'b0;
        strobe_timeout = 1'b0;
        do_finish      = 1'b0;
        fin_err        = 1'b0;
        unique case (state)
            IDLE: begin
                if (req0 || req1) begin
                    do_grant   = 1'b1;
                    // On a tie the port not granted last wins; otherwise the lone requester.
                    grant_port = (req0 && req1) ? ~gnt : req1;
                    state_next = SETUP;
                end
            end
            SETUP: state_next = STROBE;
            STROBE: begin
                if (mfc_s) begin
                    do_capture = 1'b1;
                    state_next = RELEASE;
                end else if (cnt_hit) begin
                    strobe_timeout = 1'b1;
                    state_next     = RELEASE;
                end
            end
            RELEASE: begin
                if (!mfc_s) begin
                    do_finish  = 1'b1;
                    fin_err    = err_flag;
                    state_next = IDLE;
                end else if (cnt_hit) begin
                    do_finish  = 1'b1;
                    fin_err    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Memory pins, timeout counter, captured read data and completion pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_en    <= 1'b0;
            mem_rw    <= RW_READ;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata     <= '0;
            cnt       <= '0;
            gnt       <= 1'b1;  // "port 1 went last" so port 0 wins the first tie
            err_flag  <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            err       <= 1'b0;
        end else begin
            mem_en <= (state_next == STROBE);
            done0  <= 1'b0;
            done1  <= 1'b0;
            err    <= 1'b0;

            if ((state_next == STROBE || state_next == RELEASE) && state_next != state)
                cnt <= '0;
            else if (!cnt_hit)
                cnt <= cnt + CW'(1);

            if (do_grant) begin
                gnt       <= grant_port;
                mem_rw    <= grant_port ? rw1    : rw0;
                mem_addr  <= grant_port ? addr1  : addr0;
                mem_wdata <= grant_port ? wdata1 : wdata0;
                rdata     <= '0;
                err_flag  <= 1'b0;
            end

            if (do_capture && mem_rw == RW_READ)
                rdata <= mem_rdata;

            if (strobe_timeout) begin
                err_flag <= 1'b1;
                rdata    <= '0;
            end

            if (do_finish) begin
                done0 <= ~gnt;
                done1 <= gnt;
                err   <= fin_err;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural asynchronous memory.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1, rw0, rw1;
    logic [15:0] addr0, addr1, wdata0, wdata1;
    logic        done0, done1, err, busy;
    logic [15:0] rdata;
    logic        mem_en, mem_rw, mem_mfc;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;

    // Memory model behaviour switches
    logic no_rise = 1'b0;  // MFC never rises
    logic stuck   = 1'b0;  // MFC never falls after EN drops

    int checks   = 0;
    int failures = 0;

    logic [15:0] mem [0:255];

    mem_arbiter #(.AW(16), .DW(16), .TIMEOUT(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .req1      (req1),
        .rw0       (rw0),
        .rw1       (rw1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .done0     (done0),
        .done1     (done1),
        .err       (err),
        .rdata     (rdata),
        .busy      (busy),
        .mem_en    (mem_en),
        .mem_rw    (mem_rw),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_mfc   (mem_mfc)
    );

    always #5 clk = ~clk;

    // Asynchronous memory: MFC rises 3 ns after EN, falls 3 ns after EN drops.
    initial begin : mem_model
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[1] = 16'h607E;
        mem[2] = 16'h1043;
        mem[3] = 16'h5047;
        mem_mfc   = 1'b0;
        mem_rdata = 16'h0000;
        forever begin
            @(posedge mem_en);
            #3;
            if (mem_en && !no_rise) begin
                if (mem_rw) mem_rdata = mem[mem_addr[7:0]];
                else        mem[mem_addr[7:0]] = mem_wdata;
                mem_mfc = 1'b1;
            end
            if (mem_en) @(negedge mem_en);
            wait (!stuck);
            #3;
            mem_mfc = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Issue one request on a port, hold it until its done, and report what was seen.
    task automatic run_txn(input int port, input logic rw, input logic [15:0] a,
                           input logic [15:0] wd, output int lat, output int en_cyc,
                           output logic rw_seen, output logic [15:0] rd,
                           output logic e, output logic other_done, output logic got);
        lat = 0; en_cyc = 0; rw_seen = 1'b1; rd = '0; e = 1'b0;
        other_done = 1'b0; got = 1'b0;
        if (port == 0) begin req0 = 1'b1; rw0 = rw; addr0 = a; wdata0 = wd; end
        else           begin req1 = 1'b1; rw1 = rw; addr1 = a; wdata1 = wd; end
        while (!got && lat < 60) begin
            tick();
            lat++;
            if (mem_en) begin en_cyc++; rw_seen = mem_rw; end
            if ((port == 0) ? done1 : done0) other_done = 1'b1;
            if ((port == 0) ? done0 : done1) begin got = 1'b1; rd = rdata; e = err; end
        end
        if (port == 0) req0 = 1'b0;
        else           req1 = 1'b0;
    endtask

    int          lat, en_cyc, n, cyc;
    logic        rw_seen, e, od, got, first_port;
    logic [15:0] rd;
    logic        order [4];
    logic [15:0] data  [4];

    initial begin
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; rw0 = 1'b1; rw1 = 1'b1;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

        // Reset values
        tick(); tick();
        check("rst_mem_en",    32'(mem_en),    32'(1'b0));
        check("rst_mem_rw",    32'(mem_rw),    32'(1'b1));
        check("rst_mem_addr",  32'(mem_addr),  32'(16'h0000));
        check("rst_mem_wdata", 32'(mem_wdata), 32'(16'h0000));
        check("rst_rdata",     32'(rdata),     32'(16'h0000));
        check("rst_done",      32'({done1, done0}), 32'(2'b00));
        check("rst_err",       32'(err),       32'(1'b0));
        check("rst_busy",      32'(busy),      32'(1'b0));
        reset = 1'b0;
        tick();

        // Single read, port 0
        run_txn(0, 1'b1, 16'h0001, 16'h0000, lat, en_cyc, rw_seen, rd, e, od, got);
        check("rd0_done",   32'(got),    32'(1'b1));
        check("rd0_lat",    32'(lat),    32'(8));
        check("rd0_en_cyc", 32'(en_cyc), 32'(3));
        check("rd0_rdata",  32'(rd),     32'(16'h607E));
        check("rd0_err",    32'(e),      32'(1'b0));
        check("rd0_other",  32'(od),     32'(1'b0));
        check("rd0_busy",   32'(busy),   32'(1'b0));

        // Write then read, port 1
        run_txn(1, 1'b0, 16'h0010, 16'hBEEF, lat, en_cyc, rw_seen, rd, e, od, got);
        check("wr1_done",  32'(got),     32'(1'b1));
        check("wr1_lat",   32'(lat),     32'(8));
        check("wr1_rw",    32'(rw_seen), 32'(1'b0));
        check("wr1_rdata", 32'(rd),      32'(16'h0000));
        check("wr1_err",   32'(e),       32'(1'b0));
        run_txn(1, 1'b1, 16'h0010, 16'h0000, lat, en_cyc, rw_seen, rd, e, od, got);
        check("rd1_done",  32'(got),     32'(1'b1));
        check("rd1_rw",    32'(rw_seen), 32'(1'b1));
        check("rd1_rdata", 32'(rd),      32'(16'hBEEF));

        // Both ports requesting continuously: grants alternate 0,1,0,1
        req0 = 1'b1; req1 = 1'b1; rw0 = 1'b1; rw1 = 1'b1;
        addr0 = 16'h0002; addr1 = 16'h0003;
        n = 0; cyc = 0;
        while (n < 4 && cyc < 200) begin
            tick();
            cyc++;
            if (done0 || done1) begin
                order[n] = done1;
                data[n]  = rdata;
                n++;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        check("rr_count", 32'(n), 32'(4));
        for (int i = 0; i < n; i++) begin
            check("rr_port",  32'(order[i]), 32'(i % 2));
            check("rr_rdata", 32'(data[i]),  (i % 2 == 1) ? 32'(16'h5047) : 32'(16'h1043));
        end

        // MFC never rises: strobe times out
        no_rise = 1'b1;
        run_txn(0, 1'b1, 16'h0001, 16'h0000, lat, en_cyc, rw_seen, rd, e, od, got);
        no_rise = 1'b0;
        check("to_s_done",   32'(got),    32'(1'b1));
        check("to_s_lat",    32'(lat),    32'(11));
        check("to_s_en_cyc", 32'(en_cyc), 32'(8));
        check("to_s_err",    32'(e),      32'(1'b1));
        check("to_s_rdata",  32'(rd),     32'(16'h0000));
        check("to_s_busy",   32'(busy),   32'(1'b0));

        // MFC stuck high: release phase times out, then a normal request is served
        stuck = 1'b1;
        run_txn(1, 1'b1, 16'h0003, 16'h0000, lat, en_cyc, rw_seen, rd, e, od, got);
        stuck = 1'b0;
        check("to_r_done",   32'(got),    32'(1'b1));
        check("to_r_lat",    32'(lat),    32'(13));
        check("to_r_en_cyc", 32'(en_cyc), 32'(3));
        check("to_r_err",    32'(e),      32'(1'b1));
        tick(); tick(); tick();
        check("to_r_err_low", 32'(err), 32'(1'b0));
        run_txn(0, 1'b1, 16'h0002, 16'h0000, lat, en_cyc, rw_seen, rd, e, od, got);
        check("rec_done",  32'(got), 32'(1'b1));
        check("rec_lat",   32'(lat), 32'(8));
        check("rec_rdata", 32'(rd),  32'(16'h1043));
        check("rec_err",   32'(e),   32'(1'b0));

        // Reset in the middle of a port 0 strobe
        req0 = 1'b1; rw0 = 1'b1; addr0 = 16'h0001;
        tick(); tick(); tick();
        check("mr_pre_en", 32'(mem_en), 32'(1'b1));
        #2;
        reset = 1'b1;
        #1;
        check("mr_en_async",   32'(mem_en),   32'(1'b0));
        check("mr_busy_async", 32'(busy),     32'(1'b0));
        check("mr_addr_async", 32'(mem_addr), 32'(16'h0000));
        req0 = 1'b0;
        tick();
        check("mr_no_done", 32'({done1, done0}), 32'(2'b00));
        reset = 1'b0;
        tick();

        // Tie after reset: port 0 first even though it was granted last
        req0 = 1'b1; req1 = 1'b1; addr0 = 16'h0001; addr1 = 16'h0003;
        tick();
        lat = 1;
        check("mr_setup_busy", 32'(busy),   32'(1'b1));
        check("mr_setup_en",   32'(mem_en), 32'(1'b0));
        tick();
        lat = 2;
        check("mr_strobe_en", 32'(mem_en), 32'(1'b1));
        got = 1'b0; first_port = 1'b1; rd = '0;
        while (!got && lat < 60) begin
            tick();
            lat++;
            if (done0 || done1) begin got = 1'b1; first_port = done1; rd = rdata; end
        end
        req0 = 1'b0;
        check("mr_done",  32'(got),        32'(1'b1));
        check("mr_lat",   32'(lat),        32'(8));
        check("mr_port",  32'(first_port), 32'(1'b0));
        check("mr_rdata", 32'(rd),         32'(16'h607E));

        // Port 1 granted next; it drops its request right after the grant
        tick();
        req1 = 1'b0;
        got = 1'b0; cyc = 0; rd = '0;
        while (!got && cyc < 60) begin
            tick();
            cyc++;
            if (done1) begin got = 1'b1; rd = rdata; end
        end
        check("drop_done",  32'(got), 32'(1'b1));
        check("drop_rdata", 32'(rd),  32'(16'h5047));

        tick(); tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
